// File: rtl/ram_dp_clr.sv
// Dual-port (1W/1R) register-file RAM with a self-clearing sweep.
// After reset or a clr request, every word is zeroed, one word per clock. The RAM then serves reads and writes.
module ram_dp_clr #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             w,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] d,
    input  logic             r,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] o,
    output logic             valid,
    output logic             busy,
    output logic             err
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        o_d     = o_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = waddr;
        mem_wd  = d;
        case (state_q)
            CLEAR: begin
                // The sweep owns the write port; user requests are only flagged.
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = '0;
                err_d  = r | w;
                ptr_d  = ptr_q + AW'(1);
                if (ptr_q == {AW{1'b1}}) begin
                    state_d = READY;
                    ptr_d   = '0;
                end
            end
            READY: begin
                mem_we = w & ~clr;
                if (r) begin
                    valid_d = 1'b1;
                    // Write-first: a same-address write in this cycle is forwarded.
                    o_d     = (mem_we && (waddr == raddr)) ? d : mem[raddr];
                end
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset of its own; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q == CLEAR);
endmodule
